// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Operand helpers convert raw register values to unsigned magnitudes.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  localparam int          MD_MUL_LAT_DEFAULT = 2;
  localparam logic [31:0] MD_DIVZERO_LO      = 32'hFFFF_FFFF;

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, DIV_BITS cycles.
// quotient/remainder are the post-final-step values and are valid only while core_done is high.
module muldiv_div_core #(
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kill,
  input  logic                go,
  input  logic [DIV_BITS-1:0] dividend,
  input  logic [DIV_BITS-1:0] divisor,
  output logic                busy,
  output logic                core_done,
  output logic [DIV_BITS-1:0] quotient,
  output logic [DIV_BITS-1:0] remainder
);
  localparam int CW = $clog2(DIV_BITS + 1);

  logic [DIV_BITS-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;

  logic [DIV_BITS:0]   rem_sh;
  logic                ge;
  logic [DIV_BITS-1:0] rem_d, quo_d;

  // Dividend bits shift out of quo_q into the partial remainder as quotient bits shift in.
  always_comb begin
    rem_sh = {rem_q, quo_q[DIV_BITS-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = ge ? DIV_BITS'(rem_sh - {1'b0, dvs_q}) : rem_sh[DIV_BITS-1:0];
    quo_d  = {quo_q[DIV_BITS-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (kill) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (go) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CW'(DIV_BITS);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign core_done = busy_q && (cnt_q == CW'(1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: magnitude conversion, fixed-latency
// multiply or iterative divide, sign correction, registered HI/LO and done pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = MD_MUL_LAT_DEFAULT,
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  muldiv_op_t          op,
  input  logic [DIV_BITS-1:0] a,
  input  logic [DIV_BITS-1:0] b,
  input  logic                flush,
  output logic                stall,
  output logic                done,
  output logic [DIV_BITS-1:0] hi,
  output logic [DIV_BITS-1:0] lo
);
  localparam int W  = DIV_BITS;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  muldiv_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  mag_a_q, mag_b_q, hi_q, lo_q;
  logic          neg_quo_q, neg_rem_q, done_q;

  logic          sgn, is_div, accept, div_go;
  logic [W-1:0]  mag_a, mag_b, div_q, div_r;
  logic          div_busy, div_done;
  logic [2*W-1:0] product, prod_s;

  assign sgn    = md_is_signed(op);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign accept = start && !flush && (state_q == IDLE || state_q == DONE);
  assign div_go = accept && is_div && (b != '0);
  assign mag_a  = md_mag(a, sgn);
  assign mag_b  = md_mag(b, sgn);

  assign product = {{W{1'b0}}, mag_a_q} * {{W{1'b0}}, mag_b_q};
  assign prod_s  = neg_quo_q ? -product : product;

  muldiv_div_core #(.DIV_BITS(DIV_BITS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .kill      (flush),
    .go        (div_go),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .core_done (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            state_q <= IDLE;
            if (accept) begin
              mag_a_q   <= mag_a;
              mag_b_q   <= mag_b;
              neg_quo_q <= sgn & (a[W-1] ^ b[W-1]);
              neg_rem_q <= sgn & a[W-1];
              if (!is_div) begin
                state_q <= MUL;
                cnt_q   <= CW'(MUL_LAT - 1);
              end else if (b != '0) begin
                state_q <= DIV;
              end else begin
                // Divide by zero: raw dividend to HI, all-ones quotient, no sign fix.
                state_q <= DONE;
                done_q  <= 1'b1;
                hi_q    <= a;
                lo_q    <= MD_DIVZERO_LO;
              end
            end
          end
          MUL: begin
            if (cnt_q == '0) begin
              {hi_q, lo_q} <= prod_s;
              state_q      <= DONE;
              done_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          DIV: begin
            if (div_done) begin
              lo_q    <= neg_quo_q ? -div_q : div_q;
              hi_q    <= neg_rem_q ? -div_r : div_r;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!div_busy) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign stall = accept || (state_q == MUL) || (state_q == DIV);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, random ops against a native-arithmetic
// model, and hand sequences for back-to-back, flush, reset and start+flush cases.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  muldiv_op_t  op;
  logic [31:0] a, b, hi, lo;
  logic        stall, done;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct { logic [31:0] hi; logic [31:0] lo; int lat; } exp_t;
  typedef struct { muldiv_op_t op; logic [31:0] a, b, hi, lo; int lat; } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[12];
  int          checks = 0, errors = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input muldiv_op_t o, input logic [31:0] bv);
    if (o == MD_MULT || o == MD_MULTU) return MUL_LAT + 1;
    return (bv == 0) ? 1 : 33;
  endfunction

  function automatic void model(input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sbv, r;
    logic [63:0] p;
    sa  = {{32{av[31]}}, av};
    sbv = {{32{bv[31]}}, bv};
    h = '0; l = '0;
    case (o)
      MD_MULT:  begin r = sa * sbv; {h, l} = r; end
      MD_MULTU: begin p = {32'd0, av} * {32'd0, bv}; {h, l} = p; end
      default: begin
        if (bv == 0) begin h = av; l = 32'hFFFF_FFFF; end
        else if (o == MD_DIV) begin
          r = sa / sbv; l = r[31:0];
          r = sa % sbv; h = r[31:0];
        end else begin
          l = av / bv; h = av % bv;
        end
      end
    endcase
  endfunction

  task automatic pop_cmp(input string name, input int n);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, " scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({name, " latency"}, n, e.lat);
    chk({name, " hi"}, hi, e.hi);
    chk({name, " lo"}, lo, e.lo);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Waits for done, optionally checking stall stays high until then.
  task automatic wait_done(input string name, input int lim, input bit chk_stall, output int n);
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (chk_stall) chk({name, " stall_busy"}, stall, 1);
    end
    chk({name, " done_seen"}, done, 1);
  endtask

  task automatic run_op(input string name, input muldiv_op_t o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    e.hi = eh; e.lo = el; e.lat = lat;
    sb_q.push_back(e);
    #1 chk({name, " stall_at_accept"}, stall, 1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(name, 200, 1'b1, n);
    chk({name, " stall_in_done"}, stall, 0);
    pop_cmp(name, n);
    @(negedge clk);
    chk({name, " done_one_cycle"}, done, 0);
  endtask

  task automatic no_done_for(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, " no_done"}, seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] mh, ml, ra, rb;
    muldiv_op_t  ro;

    tbl[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 3};
    tbl[1]  = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
    tbl[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[3]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    tbl[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    tbl[5]  = '{MD_DIVU,  32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, 1};
    tbl[6]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        3};
    tbl[7]  = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         3};
    tbl[8]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        3};
    tbl[9]  = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
    tbl[10] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};
    tbl[11] = '{MD_DIVU,  32'd5,         32'd9,        32'd5,         32'd0,         33};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset stall", stall, 0);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                            tbl[i].hi, tbl[i].lo, tbl[i].lat);

    for (int i = 0; i < 10; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 5000)) : $urandom);
      if (ro == MD_DIV && i % 3 == 0) rb = -rb;
      model(ro, ra, rb, mh, ml);
      run_op($sformatf("rand%0d", i), ro, ra, rb, mh, ml, lat_of(ro, rb));
    end

    // Back-to-back: second request held high through the busy period.
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    sb_q.push_back('{32'd2, 32'd14, 33});
    @(posedge clk);
    #1 op = MD_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    wait_done("b2b_first", 100, 1'b1, n);
    chk("b2b_first stall_reaccept", stall, 1);
    pop_cmp("b2b_first", n);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b_second", 100, 1'b1, n);
    pop_cmp("b2b_second", n);
    @(negedge clk);

    // Flush mid-divide: no completion, results keep prior values.
    start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush done", done, 0);
    chk("flush stall", stall, 0);
    chk("flush hi", hi, last_hi);
    chk("flush lo", lo, last_lo);
    no_done_for("flush", 40);
    run_op("post_flush_multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'd1, 3);

    // Reset mid-divide.
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset done", done, 0);
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    chk("midreset stall", stall, 0);
    no_done_for("midreset", 40);

    // Start together with flush in IDLE is refused.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4;
    #1 chk("start_flush stall_same", stall, 0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("start_flush stall_next", stall, 0);
    no_done_for("start_flush", 6);
    chk("start_flush lo", lo, 0);

    run_op("final_mult", MD_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
